// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory port between the instruction-fetch and data masters.
// One outstanding transaction, registered master-side outputs, watchdog timeout on missing m_ack.
module mem_bus_arbiter #(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic [DW-1:0]   if_rdata,
  output logic            if_ack,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [DW/8-1:0] d_sel,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  output logic [DW-1:0]   d_rdata,
  output logic            d_ack,
  output logic            m_ce,
  output logic            m_we,
  output logic [DW/8-1:0] m_sel,
  output logic [AW-1:0]   m_addr,
  output logic [DW-1:0]   m_wdata,
  input  logic [DW-1:0]   m_rdata,
  input  logic            m_ack,
  output logic            stallreq,
  output logic            bus_err
);

  localparam int unsigned SW = DW / 8;
  localparam int unsigned CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CW-1:0] CntMax = CW'(MAX_WAIT - 1);

  typedef enum logic [1:0] {StIdle, StBusyI, StBusyD} state_e;

  state_e          state_q, state_d;
  logic            last_d_q, last_d_d;
  logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
  logic            m_ce_q, m_ce_d;
  logic            m_we_q, m_we_d;
  logic [SW-1:0]   m_sel_q, m_sel_d;
  logic [AW-1:0]   m_addr_q, m_addr_d;
  logic [DW-1:0]   m_wdata_q, m_wdata_d;
  logic [DW-1:0]   if_rdata_q, if_rdata_d;
  logic [DW-1:0]   d_rdata_q, d_rdata_d;
  logic            if_ack_q, if_ack_d;
  logic            d_ack_q, d_ack_d;
  logic            bus_err_q, bus_err_d;
  logic            grant_i, grant_d;
  logic [DW-1:0]   cap_rdata;

  always_comb begin
    state_d    = state_q;
    last_d_d   = last_d_q;
    wait_cnt_d = wait_cnt_q;
    m_ce_d     = m_ce_q;
    m_we_d     = m_we_q;
    m_sel_d    = m_sel_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_ack_d   = 1'b0;
    d_ack_d    = 1'b0;
    bus_err_d  = 1'b0;
    // On contention the master that was not served last wins.
    grant_i    = if_req && (!d_req || last_d_q);
    grant_d    = d_req && (!if_req || !last_d_q);
    cap_rdata  = m_ack ? m_rdata : '0;

    unique case (state_q)
      StIdle: begin
        // Skip arbitration while the previous completion pulse is still visible.
        if (!(if_ack_q || d_ack_q)) begin
          if (grant_i) begin
            state_d    = StBusyI;
            last_d_d   = 1'b0;
            wait_cnt_d = '0;
            m_ce_d     = 1'b1;
            m_we_d     = 1'b0;
            m_sel_d    = '1;
            m_addr_d   = if_addr;
            m_wdata_d  = '0;
          end else if (grant_d) begin
            state_d    = StBusyD;
            last_d_d   = 1'b1;
            wait_cnt_d = '0;
            m_ce_d     = 1'b1;
            m_we_d     = d_we;
            m_sel_d    = d_sel;
            m_addr_d   = d_addr;
            m_wdata_d  = d_wdata;
          end
        end
      end
      StBusyI, StBusyD: begin
        // m_ack in the final watchdog cycle still counts as a normal completion.
        if (m_ack || (wait_cnt_q == CntMax)) begin
          state_d    = StIdle;
          wait_cnt_d = '0;
          m_ce_d     = 1'b0;
          m_we_d     = 1'b0;
          m_sel_d    = '0;
          m_addr_d   = '0;
          m_wdata_d  = '0;
          bus_err_d  = !m_ack;
          if (state_q == StBusyI) begin
            if_ack_d   = 1'b1;
            if_rdata_d = cap_rdata;
          end else begin
            d_ack_d   = 1'b1;
            d_rdata_d = cap_rdata;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      last_d_q   <= 1'b1;
      wait_cnt_q <= '0;
      m_ce_q     <= 1'b0;
      m_we_q     <= 1'b0;
      m_sel_q    <= '0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_ack_q   <= 1'b0;
      d_ack_q    <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_d_q   <= last_d_d;
      wait_cnt_q <= wait_cnt_d;
      m_ce_q     <= m_ce_d;
      m_we_q     <= m_we_d;
      m_sel_q    <= m_sel_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      if_ack_q   <= if_ack_d;
      d_ack_q    <= d_ack_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign m_ce     = m_ce_q;
  assign m_we     = m_we_q;
  assign m_sel    = m_sel_q;
  assign m_addr   = m_addr_q;
  assign m_wdata  = m_wdata_q;
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign if_ack   = if_ack_q;
  assign d_ack    = d_ack_q;
  assign bus_err  = bus_err_q;
  assign stallreq = (if_req & ~if_ack_q) | (d_req & ~d_ack_q);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: table of single transfers, round-robin and reset sequences,
// completions checked against a scoreboard queue.
module tb_mem_bus_arbiter;

  localparam int unsigned AW       = 32;
  localparam int unsigned DW       = 32;
  localparam int unsigned MAX_WAIT = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_req = 1'b0;
  logic [31:0]   if_addr = '0;
  logic [31:0]   if_rdata;
  logic          if_ack;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [3:0]    d_sel = '0;
  logic [31:0]   d_addr = '0;
  logic [31:0]   d_wdata = '0;
  logic [31:0]   d_rdata;
  logic          d_ack;
  logic          m_ce;
  logic          m_we;
  logic [3:0]    m_sel;
  logic [31:0]   m_addr;
  logic [31:0]   m_wdata;
  logic [31:0]   m_rdata = '0;
  logic          m_ack = 1'b0;
  logic          stallreq;
  logic          bus_err;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_sel(d_sel), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .m_ce(m_ce), .m_we(m_we), .m_sel(m_sel), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack), .stallreq(stallreq), .bus_err(bus_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        is_d;
    logic [31:0] rdata;
    logic        err;
  } sb_t;

  sb_t sb_q[$];
  sb_t sb_e;
  int  acks_in_txn = 0;
  logic prev_ce_n = 1'b0;

  // Completion monitor: pops the scoreboard on every ack and checks bus invariants.
  always @(negedge clk) begin
    if (m_ce && !prev_ce_n) acks_in_txn = 0;
    prev_ce_n = m_ce;
    check("no_double_ack", 32'(if_ack & d_ack), 32'd0);
    check("no_ack_with_ce", 32'(m_ce & (if_ack | d_ack)), 32'd0);
    if (if_ack || d_ack) begin
      acks_in_txn++;
      check("one_ack_per_txn", 32'(acks_in_txn <= 1), 32'd1);
      check("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
      if (sb_q.size() > 0) begin
        sb_e = sb_q.pop_front();
        check("ack_master", 32'(d_ack), 32'(sb_e.is_d));
        check("ack_rdata", d_ack ? d_rdata : if_rdata, sb_e.rdata);
        check("ack_bus_err", 32'(bus_err), 32'(sb_e.err));
      end
    end else begin
      check("no_stray_bus_err", 32'(bus_err), 32'd0);
    end
  end

  typedef struct {
    logic        is_d;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrdata;
    int          delay;    // cycles after m_ce before m_ack; >= MAX_WAIT means never
    logic        x_we;
    logic [3:0]  x_sel;
    logic [31:0] x_wdata;
    logic [31:0] x_rdata;
    logic        x_err;
    int          x_lat;    // edges from m_ce rising to the ack
  } vec_t;

  vec_t vecs[7];
  logic [31:0] last_if_rdata = '0;
  logic [31:0] last_d_rdata = '0;

  task automatic run_vec(input vec_t v);
    int  ce_edge = 0;
    bit  seen = 0;
    bit  done = 0;
    sb_q.push_back('{v.is_d, v.x_rdata, v.x_err});
    if (v.is_d) begin
      d_req = 1'b1; d_we = v.we; d_sel = v.sel; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    m_rdata = v.mrdata;
    for (int n = 1; n <= 40 && !done; n++) begin
      @(posedge clk); #1;
      if (m_ce && !seen) begin
        seen = 1; ce_edge = n;
        check("grant_latency", n, 32'd1);
        check("m_addr", m_addr, v.addr);
        check("m_we", 32'(m_we), 32'(v.x_we));
        check("m_sel", 32'(m_sel), 32'(v.x_sel));
        check("m_wdata", m_wdata, v.x_wdata);
      end
      if (if_ack || d_ack) begin
        done = 1;
        check("ack_latency", n - ce_edge, v.x_lat);
        check("stallreq_at_ack", 32'(stallreq), 32'd0);
        if (v.is_d) begin
          check("if_rdata_hold", if_rdata, last_if_rdata);
          last_d_rdata = v.x_rdata;
        end else begin
          check("d_rdata_hold", d_rdata, last_d_rdata);
          last_if_rdata = v.x_rdata;
        end
        if_req = 1'b0; d_req = 1'b0; m_ack = 1'b0;
      end else begin
        check("stallreq_pending", 32'(stallreq), 32'd1);
        m_ack = seen && ((n - ce_edge) >= v.delay);
      end
    end
    check("ack_seen", 32'(done), 32'd1);
    if_req = 1'b0; d_req = 1'b0; m_ack = 1'b0;
    @(posedge clk); #1;
    check("idle_after_ack", 32'(m_ce), 32'd0);
  endtask

  initial begin
    int grants = 0;
    int acks = 0;
    int last_g = 0;
    logic prev_ce = 1'b0;
    logic [31:0] exp_addr;

    //          is_d we  sel    addr          wdata         mrdata        dly  xwe  xsel   xwdata        xrdata        xerr lat
    vecs[0] = '{1'b0, 1'b0, 4'h0, 32'h0000_0100, 32'h0,        32'h3C01_1234, 1,   1'b0, 4'hF, 32'h0,        32'h3C01_1234, 1'b0, 2};
    vecs[1] = '{1'b1, 1'b1, 4'h3, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,        0,   1'b1, 4'h3, 32'hDEAD_BEEF, 32'h0,        1'b0, 1};
    vecs[2] = '{1'b1, 1'b0, 4'hF, 32'h2000_0004, 32'h1111_1111, 32'hCAFE_F00D, 3,   1'b0, 4'hF, 32'h1111_1111, 32'hCAFE_F00D, 1'b0, 4};
    vecs[3] = '{1'b0, 1'b0, 4'h0, 32'h0000_0204, 32'h0,        32'h0BAD_C0DE, 14,  1'b0, 4'hF, 32'h0,        32'h0BAD_C0DE, 1'b0, 15};
    vecs[4] = '{1'b1, 1'b0, 4'hF, 32'h0000_0080, 32'h0,        32'h7777_7777, 255, 1'b0, 4'hF, 32'h0,        32'h0,        1'b1, 15};
    vecs[5] = '{1'b0, 1'b0, 4'h0, 32'h0000_0300, 32'h0,        32'h6666_6666, 255, 1'b0, 4'hF, 32'h0,        32'h0,        1'b1, 15};
    vecs[6] = '{1'b1, 1'b1, 4'hC, 32'h0000_0044, 32'h0123_4567, 32'h0,        2,   1'b1, 4'hC, 32'h0123_4567, 32'h0,        1'b0, 3};

    repeat (3) @(posedge clk);
    #1;
    check("rst_m_ce", 32'(m_ce), 32'd0);
    check("rst_m_addr", m_addr, 32'd0);
    check("rst_m_sel", 32'(m_sel), 32'd0);
    check("rst_if_ack", 32'(if_ack), 32'd0);
    check("rst_d_ack", 32'(d_ack), 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    check("rst_bus_err", 32'(bus_err), 32'd0);
    check("rst_stallreq", 32'(stallreq), 32'd0);

    // Both masters requesting continuously from reset: expect I, D, I, D.
    rst = 1'b0;
    if_req = 1'b1; if_addr = 32'h0000_1000;
    d_req = 1'b1; d_we = 1'b0; d_sel = 4'hF; d_addr = 32'h0000_2000; d_wdata = '0;
    m_ack = 1'b1;
    for (int k = 0; k < 4; k++)
      sb_q.push_back('{k[0], (k[0] ? ~32'h0000_2000 : ~32'h0000_1000), 1'b0});
    for (int n = 1; n <= 40 && acks < 4; n++) begin
      @(posedge clk); #1;
      m_rdata = ~m_addr;
      if (m_ce && !prev_ce) begin
        exp_addr = grants[0] ? 32'h0000_2000 : 32'h0000_1000;
        check("rr_order", m_addr, exp_addr);
        if (grants > 0) check("rr_spacing", n - last_g, 32'd3);
        last_g = n;
        grants++;
      end
      prev_ce = m_ce;
      if (if_ack || d_ack) acks++;
    end
    if_req = 1'b0; d_req = 1'b0; m_ack = 1'b0;
    check("rr_acks", acks, 32'd4);
    @(posedge clk); #1;
    last_if_rdata = ~32'h0000_1000;
    last_d_rdata  = ~32'h0000_2000;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset while BUSY_I: transaction vanishes, late m_ack is ignored.
    if_req = 1'b1; if_addr = 32'h0000_0400;
    @(posedge clk); #1;
    check("pre_rst_ce", 32'(m_ce), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; if_req = 1'b0;
    check("rst_busy_ce", 32'(m_ce), 32'd0);
    check("rst_busy_if_ack", 32'(if_ack), 32'd0);
    check("rst_busy_bus_err", 32'(bus_err), 32'd0);
    check("rst_busy_if_rdata", if_rdata, 32'd0);
    m_ack = 1'b1; m_rdata = 32'h5555_AAAA;
    repeat (3) begin
      @(posedge clk); #1;
      check("late_ack_ignored", 32'(if_ack | d_ack | m_ce), 32'd0);
    end
    m_ack = 1'b0;
    last_if_rdata = '0;
    last_d_rdata  = '0;
    run_vec(vecs[0]);

    repeat (2) @(posedge clk);
    #1;
    check("sb_drained", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
